// File: rtl/wb_arbiter_pkg.sv
// Shared writeback/register-file constants and the requester index type.
package wb_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_idx_e;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
    addr_onehot       = '0;
    addr_onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_hold_entry.sv
// One held writeback request: valid, destination, data and an age bit
// (young = loaded while the other requester's entry was already waiting).
module wb_hold_entry
  import wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic                  i_young,
  input  logic                  i_age_clr,
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]       i_data,
  output logic                  o_valid,
  output logic                  o_young,
  output logic [REG_ADDR_W-1:0] o_addr,
  output logic [XLEN-1:0]       o_data
);

  logic                  r_valid;
  logic                  r_young;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]       r_data;

  // A load in the same cycle as the clear wins, so a granted entry can be refilled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_young <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_young <= i_young;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else begin
      if (i_clear)   r_valid <= 1'b0;
      if (i_age_clr) r_young <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_young = r_young;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter (ALU, LSU) with one hold entry each.
// Define WB_ARB_RR_EN for round-robin between distinct addresses; default is fixed ALU priority.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_addr,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_data,
  output logic [NUM_REGS-1:0]   pend_mask
);

  logic                  w_alu_held, w_alu_young, w_alu_load, w_alu_stay, w_gnt_alu;
  logic                  w_lsu_held, w_lsu_young, w_lsu_load, w_lsu_stay, w_gnt_lsu;
  logic [REG_ADDR_W-1:0] w_alu_addr, w_lsu_addr;
  logic [XLEN-1:0]       w_alu_data, w_lsu_data;
  logic                  w_both;
  req_idx_e              w_winner;

  assign w_both = w_alu_held & w_lsu_held;

`ifdef WB_ARB_RR_EN
  logic r_rr_lsu;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_rr_lsu <= 1'b0;
    else if (w_both) r_rr_lsu <= (w_winner == REQ_ALU);
  end
`endif

  always_comb begin
    w_winner = REQ_ALU;
    if (w_both) begin
      // Same destination: the older entry goes first to keep write order.
      if (w_alu_addr == w_lsu_addr) begin
        w_winner = w_alu_young ? REQ_LSU : REQ_ALU;
      end else begin
`ifdef WB_ARB_RR_EN
        w_winner = r_rr_lsu ? REQ_LSU : REQ_ALU;
`else
        w_winner = REQ_ALU;
`endif
      end
    end else if (w_lsu_held) begin
      w_winner = REQ_LSU;
    end
  end

  assign w_gnt_alu = w_alu_held & (w_winner == REQ_ALU);
  assign w_gnt_lsu = w_lsu_held & (w_winner == REQ_LSU);

  assign alu_ready = ~w_alu_held | w_gnt_alu;
  assign lsu_ready = ~w_lsu_held | w_gnt_lsu;

  assign w_alu_load = alu_valid & alu_ready & (alu_addr != '0);
  assign w_lsu_load = lsu_valid & lsu_ready & (lsu_addr != '0);
  assign w_alu_stay = w_alu_held & ~w_gnt_alu;
  assign w_lsu_stay = w_lsu_held & ~w_gnt_lsu;

  // Simultaneous loads rank the ALU older; a load next to a waiting entry is younger.
  wb_hold_entry u_alu_entry (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (w_alu_load),
    .i_clear   (w_gnt_alu),
    .i_young   (w_lsu_stay),
    .i_age_clr (w_lsu_load),
    .i_addr    (alu_addr),
    .i_data    (alu_data),
    .o_valid   (w_alu_held),
    .o_young   (w_alu_young),
    .o_addr    (w_alu_addr),
    .o_data    (w_alu_data)
  );

  wb_hold_entry u_lsu_entry (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (w_lsu_load),
    .i_clear   (w_gnt_lsu),
    .i_young   (w_alu_stay | w_alu_load),
    .i_age_clr (w_alu_load),
    .i_addr    (lsu_addr),
    .i_data    (lsu_data),
    .o_valid   (w_lsu_held),
    .o_young   (w_lsu_young),
    .o_addr    (w_lsu_addr),
    .o_data    (w_lsu_data)
  );

  always_comb begin
    write_en   = w_gnt_alu | w_gnt_lsu;
    write_addr = '0;
    write_data = '0;
    if (w_gnt_alu) begin
      write_addr = w_alu_addr;
      write_data = w_alu_data;
    end else if (w_gnt_lsu) begin
      write_addr = w_lsu_addr;
      write_data = w_lsu_data;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (w_alu_held) pend_mask = pend_mask | addr_onehot(w_alu_addr);
    if (w_lsu_held) pend_mask = pend_mask | addr_onehot(w_lsu_addr);
  end

  // The LSU age bit is only consulted through the ALU's; both are kept for symmetry.
  logic w_unused;
  assign w_unused = w_lsu_young;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a sequence-number reference model predicts every cycle.
module tb_wb_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ar;
    logic        lr;
    logic [31:0] pm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_addr, lsu_addr;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] pend_mask;

  int n_checks = 0;
  int n_errors = 0;
  int lsu_wr_cnt = 0;
  exp_t exp_q[$];

  // Reference model: each held request carries its arrival order number.
  bit          m_held[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int unsigned m_seq[2];
  bit          m_fav_lsu;
  int unsigned m_time;

  wb_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_addr   (lsu_addr),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .pend_mask  (pend_mask)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_held[0] = 0; m_held[1] = 0;
    m_fav_lsu = 0;
  endfunction

  function automatic int model_grant();
    if (!m_held[0] && !m_held[1]) return -1;
    if (!m_held[1]) return 0;
    if (!m_held[0]) return 1;
    if (m_addr[0] == m_addr[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
`ifdef WB_ARB_RR_EN
    return m_fav_lsu ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] m = '0;
    for (int i = 0; i < 2; i++) if (m_held[i]) m[m_addr[i]] = 1'b1;
    return m;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld);
    exp_t e;
    int   g;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    g    = model_grant();
    e.we = (g >= 0);
    e.wa = (g == 0) ? m_addr[0] : (g == 1) ? m_addr[1] : 5'd0;
    e.wd = (g == 0) ? m_data[0] : (g == 1) ? m_data[1] : 32'd0;
    e.ar = !m_held[0] || g == 0;
    e.lr = !m_held[1] || g == 1;
    e.pm = model_pend();
    exp_q.push_back(e);
    @(posedge clk);
    if (rstn) begin
      if (m_held[0] && m_held[1]) m_fav_lsu = (g == 0);
      if (g >= 0) m_held[g] = 0;
      if (av && e.ar && aa != 0) begin
        m_held[0] = 1; m_addr[0] = aa; m_data[0] = ad; m_seq[0] = 2 * m_time;
      end
      if (lv && e.lr && la != 0) begin
        m_held[1] = 1; m_addr[1] = la; m_data[1] = ld; m_seq[1] = 2 * m_time + 1;
      end
      m_time++;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("write_en",   {31'd0, write_en},  {31'd0, e.we});
      check("write_addr", {27'd0, write_addr}, {27'd0, e.wa});
      check("write_data", write_data, e.wd);
      check("alu_ready",  {31'd0, alu_ready}, {31'd0, e.ar});
      check("lsu_ready",  {31'd0, lsu_ready}, {31'd0, e.lr});
      check("pend_mask",  pend_mask, e.pm);
      if (write_en && write_data[31:28] == 4'hB) lsu_wr_cnt++;
    end
  end

  initial begin
    int exp_lsu;
    rstn = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    model_reset();
    m_time = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_write_en", {31'd0, write_en}, 32'd0);
    check("rst_pend", pend_mask, 32'd0);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    rstn = 1;

    // Single ALU write, one-cycle latency.
    step(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
    check("r027_we", {31'd0, write_en}, 32'd1);
    check("r027_addr", {27'd0, write_addr}, 32'd5);
    check("r027_data", write_data, 32'h1234);
    check("r027_pend", pend_mask, 32'h20);
    idle();
    check("r027_done", {31'd0, write_en}, 32'd0);

    // Address 0 is swallowed.
    step(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'd0);
    check("r030_ready", {31'd0, alu_ready}, 32'd1);
    check("r030_we", {31'd0, write_en}, 32'd0);
    check("r030_pend", pend_mask, 32'd0);

    // Same-address ordering: older LSU r9 write goes before the ALU one.
    step(1, 5'd4, 32'h44, 1, 5'd9, 32'hA);
    step(1, 5'd9, 32'hB, 0, 5'd0, 32'd0);
    check("r029_first_addr", {27'd0, write_addr}, 32'd9);
    check("r029_first_data", write_data, 32'hA);
    idle();
    check("r029_second_data", write_data, 32'hB);
    idle();

    // Simultaneous accept: r3 then r7.
    step(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
    check("r028_first", {27'd0, write_addr}, 32'd3);
    check("r028_lsu_blocked", {31'd0, lsu_ready}, 32'd0);
    idle();
    check("r028_second", {27'd0, write_addr}, 32'd7);
    idle();

    // Reset with both entries held.
    step(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
    alu_valid = 0; lsu_valid = 0;
    rstn = 0;
    #1;
    check("r032_we", {31'd0, write_en}, 32'd0);
    check("r032_addr", {27'd0, write_addr}, 32'd0);
    check("r032_data", write_data, 32'd0);
    check("r032_pend", pend_mask, 32'd0);
    check("r032_ready", {30'd0, alu_ready, lsu_ready}, 32'd3);
    model_reset();
    exp_q.push_back('{we: 0, wa: 0, wd: 0, ar: 1, lr: 1, pm: 0});
    @(posedge clk);
    #1;
    rstn = 1;
    repeat (3) idle();

    // Both requesters streaming distinct addresses.
    lsu_wr_cnt = 0;
    for (int i = 0; i < 20; i++)
      step(1, 5'(1 + i % 15), 32'hA000_0000 | i, 1, 5'(16 + i % 16), 32'hB000_0000 | i);
`ifdef WB_ARB_RR_EN
    exp_lsu = 9;
`else
    exp_lsu = 0;
`endif
    check("r031_lsu_grants", lsu_wr_cnt, exp_lsu);
    repeat (4) idle();

    // Random traffic with a narrow address range to provoke collisions and r0.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] aa, la;
      aa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      la = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      step($urandom_range(0, 2) != 0, aa, $urandom, $urandom_range(0, 2) != 0, la, $urandom);
    end
    repeat (4) idle();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have these ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have these ports: rstn  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have these ports: alu_valid  in  1  ALU writeback request.
REQ-004 SHALL have these ports: alu_addr  in  5  ALU destination register.
REQ-005 SHALL have these ports: alu_data  in  32  ALU result.
REQ-006 SHALL have these ports: alu_ready  out  1  ALU request accepted this cycle when high with alu_valid.
REQ-007 SHALL have these ports: lsu_valid, lsu_addr, lsu_data, lsu_ready  in/in/in/out  1/5/32/1  same meaning for the load unit.
REQ-008 SHALL have these ports: write_en, write_addr, write_data  out  1/5/32  register-file write port.
REQ-009 SHALL have this port: pend_mask  out  32  bit r high while a write to register r is held; bit 0 always 0.

Function
REQ-010 SHALL hold one entry per requester (valid, addr, data, age bit); a handshake (valid && ready) at edge N loads the entry.
REQ-011 SHALL drive ready_x = !hold_valid_x || grant_x, combinationally from registered state only, independent of valid_x.
REQ-012 SHALL discard accepted requests with addr 0: no entry loaded, no write issued, ready unaffected.
REQ-013 SHALL grant at most one held entry per cycle; write_en = any grant, write_addr/write_data = winner's entry, combinationally; the register file commits at the following edge.
REQ-014 SHALL give latency exactly 1 cycle: accepted at edge N, write_en high in cycle N..N+1, committed at edge N+1, provided no conflict.
REQ-015 SHALL clear the granted entry at the edge ending its grant cycle; a same-cycle new handshake on that requester reloads it.
REQ-016 SHALL apply default priority: ALU entry beats LSU entry.
REQ-017 SHALL, when both entries hold the same addr, grant the older entry (age bit) regardless of priority, preserving write order.
REQ-018 SHALL set the age bit of an entry loaded while the other entry is held to "younger", and SHALL count simultaneous loads as ALU older.
REQ-019 SHALL drive write_en, write_addr and write_data to 0 when nothing is held.
REQ-020 SHALL compute pend_mask as the OR of one-hot decodes of held addresses.

Reset
REQ-021 SHALL, on rstn low, immediately clear both entries, age bits and round-robin pointer; write_en=0, write_addr=0, write_data=0, pend_mask=0, alu_ready=1, lsu_ready=1.
REQ-022 SHALL drop held and in-flight requests on reset mid-operation, with no write issued after rstn rises.

Configuration
REQ-023 SHALL use macro WB_ARB_RR_EN: when defined, replace REQ-016 with round-robin (pointer toggles to the loser after each contested grant; initial favour ALU); when undefined, fixed ALU priority and no pointer register.
REQ-024 SHALL keep REQ-017 same-address ordering in force in both configurations.

Structure
REQ-025 SHALL place XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the requester-index enum (REQ_ALU=0, REQ_LSU=1) in a shared package reused by reg_file users.
REQ-026 SHALL use one sub-module, wb_hold_entry (valid/addr/data/age register with load/clear), instantiated once per requester; arbitration stays in the top level.

Verification
REQ-027 SHALL cover: alu_valid=1, addr=5, data=0x1234 with idle LSU -> write_en=1, addr=5, data=0x1234 the next cycle; pend_mask=0x20 during that cycle.
REQ-028 SHALL cover: ALU addr 3 and LSU addr 7 accepted on the same edge, fixed priority -> cycle 1 writes r3, cycle 2 writes r7; lsu_ready=0 in cycle 1.
REQ-029 SHALL cover: LSU addr 9 data 0xA held and blocked, then ALU addr 9 data 0xB accepted -> r9 written 0xA first, then 0xB.
REQ-030 SHALL cover: ALU addr 0 data 0xFFFF accepted -> alu_ready stays 1, write_en stays 0, pend_mask=0.
REQ-031 SHALL cover: both requesters streaming distinct addrs every cycle with WB_ARB_RR_EN defined -> grants alternate ALU,LSU,ALU,...; undefined -> LSU starves while ALU streams.
REQ-032 SHALL cover: rstn pulled low with both entries held -> outputs at reset values within the same cycle; after release, no write_en until a new handshake.
